// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C transaction sequencer.
// Holds the FSM state enum, the bus field widths and the default timeout.
package i2c_pkg;

   localparam int          ADDR_W      = 7;
   localparam int          DATA_W      = 8;
   localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the index
// that was not granted last. The pointer favours index 0 out of reset.
module i2c_rr_arbiter
   import i2c_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_gnt_vld,
   output logic       o_gnt_idx
);

   logic r_last;
   logic w_idx;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_idx = 1'b0;
      case (i_req)
         2'b01:   w_idx = 1'b0;
         2'b10:   w_idx = 1'b1;
         2'b11:   w_idx = ~r_last;
         default: w_idx = 1'b0;
      endcase
   end

   assign o_gnt_vld = |i_req;
   assign o_gnt_idx = w_idx;

   // NOTE: state registers use non-blocking assignments and an async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last <= 1'b1;
      end else if (i_take && o_gnt_vld) begin
         r_last <= w_idx;
      end
   end

endmodule

// File: rtl/i2c_arb_seq.sv
// Arbitrates two requesters onto one i2c_master: latches the winner's request,
// drives the master from those latches and reports completion or timeout.
module i2c_arb_seq
   import i2c_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_rw,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic [1:0]        req_ack,
   output logic [1:0]        rsp_done,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mst_en,
   output logic              mst_rw,
   output logic [ADDR_W-1:0] mst_addr,
   output logic [DATA_W-1:0] mst_data,
   input  logic              mst_ready,
   input  logic [DATA_W-1:0] mst_data_out
);

   state_t            r_state;
   state_t            w_next;
   logic              r_idx;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [15:0]       r_tmo;
   logic [1:0]        r_ack;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;

   logic w_gnt_vld;
   logic w_gnt_idx;
   logic w_take;
   logic w_tmo_hit;
   logic w_tmo_abort;

   i2c_rr_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (req_valid),
      .i_take    (w_take),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_idx (w_gnt_idx)
   );

   assign w_take    = (r_state == ST_IDLE) && mst_ready && w_gnt_vld;
   // >= rather than == so an acceptance landing on the limit still times out in BUSY
   assign w_tmo_hit = (r_tmo >= (TIMEOUT - 16'd1));

   always_comb begin
      w_next      = r_state;
      w_tmo_abort = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_take) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!mst_ready) begin
               w_next = ST_BUSY;
            end else if (w_tmo_hit) begin
               w_next      = ST_DONE;
               w_tmo_abort = 1'b1;
            end
         end
         ST_BUSY: begin
            if (mst_ready) begin
               w_next = ST_DONE;
            end else if (w_tmo_hit) begin
               w_next      = ST_DONE;
               w_tmo_abort = 1'b1;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= 1'b0;
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_tmo   <= '0;
         r_ack   <= 2'b00;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_ack   <= 2'b00;
         r_err   <= w_tmo_abort;

         if (w_take) begin
            r_idx  <= w_gnt_idx;
            r_rw   <= req_rw[w_gnt_idx];
            r_addr <= w_gnt_idx ? req_addr1 : req_addr0;
            r_data <= w_gnt_idx ? req_data1 : req_data0;
            r_ack  <= idx_onehot(w_gnt_idx);
            r_tmo  <= '0;
         end else if ((r_state == ST_ISSUE) || (r_state == ST_BUSY)) begin
            r_tmo <= r_tmo + 16'd1;
         end

         // read byte is only taken on a genuine completion; timeouts and writes report zero
         if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
            r_rdata <= (r_rw && !w_tmo_abort) ? mst_data_out : '0;
         end
      end
   end

   assign req_ack  = r_ack;
   assign rsp_done = (r_state == ST_DONE) ? idx_onehot(r_idx) : 2'b00;
   assign rsp_err  = r_err;
   assign rsp_data = r_rdata;
   assign mst_en   = (r_state == ST_ISSUE);
   assign mst_rw   = r_rw;
   assign mst_addr = r_addr;
   assign mst_data = r_data;

endmodule

// File: tb/tb_i2c_arb_seq.sv
// Self-checking bench for i2c_arb_seq: directed vector table, contention and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_i2c_arb_seq;
   import i2c_pkg::*;

   localparam logic [15:0] TMO = 16'd100;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_rw;
   logic [6:0] req_addr0, req_addr1;
   logic [7:0] req_data0, req_data1;
   logic [1:0] req_ack;
   logic [1:0] rsp_done;
   logic       rsp_err;
   logic [7:0] rsp_data;
   logic       mst_en, mst_rw;
   logic [6:0] mst_addr;
   logic [7:0] mst_data;
   logic       mst_ready;
   logic [7:0] mst_data_out;

   int errors = 0;
   int checks = 0;

   // reference state: index granted last (1 means index 0 is favoured next)
   logic tb_last = 1'b1;

   // master model controls and the read bytes it has returned, in order
   bit         m_hang  = 1'b0;
   bit         m_rand  = 1'b0;
   int         m_busy  = 20;
   logic [7:0] m_rdata = 8'h00;
   logic [7:0] rdata_q[$];

   always #5 clk = ~clk;

   i2c_arb_seq #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_rw       (req_rw),
      .req_addr0    (req_addr0),
      .req_addr1    (req_addr1),
      .req_data0    (req_data0),
      .req_data1    (req_data1),
      .req_ack      (req_ack),
      .rsp_done     (rsp_done),
      .rsp_err      (rsp_err),
      .rsp_data     (rsp_data),
      .mst_en       (mst_en),
      .mst_rw       (mst_rw),
      .mst_addr     (mst_addr),
      .mst_data     (mst_data),
      .mst_ready    (mst_ready),
      .mst_data_out (mst_data_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // i2c_master stand-in: accepts on mst_en, stays busy, then returns a byte
   initial begin
      mst_ready    = 1'b1;
      mst_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (mst_en === 1'b1 && !m_hang) begin
            int n;
            n = m_rand ? int'($urandom_range(1, 40)) : m_busy;
            mst_ready = 1'b0;
            repeat (n) @(negedge clk);
            mst_data_out = m_rand ? 8'($urandom) : m_rdata;
            rdata_q.push_back(mst_data_out);
            mst_ready = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input logic idx, input logic rw, input logic [6:0] addr, input logic [7:0] data);
      req_rw[idx] = rw;
      if (idx) begin
         req_addr1 = addr;
         req_data1 = data;
      end else begin
         req_addr0 = addr;
         req_data0 = data;
      end
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ack == 2'b00 && n < 300);
      check("ack within bound", 32'(n < 300), 32'd1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_done == 2'b00 && n < 300);
      check("done within bound", 32'(n < 300), 32'd1);
   endtask

   typedef struct {
      logic       idx;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
      int         busy;
      logic [7:0] rdata;
      bit         hang;
      logic [1:0] exp_done;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      m_rand  = 1'b0;
      m_busy  = v.busy;
      m_rdata = v.rdata;
      m_hang  = v.hang;
      @(negedge clk);
      set_req(v.idx, v.rw, v.addr, v.data);
      req_valid = v.idx ? 2'b10 : 2'b01;
      @(negedge clk);
      check({tag, " ack"}, 32'(req_ack), 32'(idx_onehot(v.idx)));
      check({tag, " mst_en"}, 32'(mst_en), 32'd1);
      check({tag, " mst_addr"}, 32'(mst_addr), 32'(v.addr));
      check({tag, " mst_data"}, 32'(mst_data), 32'(v.data));
      check({tag, " mst_rw"}, 32'(mst_rw), 32'(v.rw));
      tb_last   = v.idx;
      req_valid = 2'b00;
      set_req(v.idx, ~v.rw, ~v.addr, ~v.data);
      lat = 0;
      while (rsp_done == 2'b00 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " done"}, 32'(rsp_done), 32'(v.exp_done));
      check({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
      check({tag, " data"}, 32'(rsp_data), 32'(v.exp_data));
      check({tag, " addr held"}, 32'(mst_addr), 32'(v.addr));
      check({tag, " data held"}, 32'(mst_data), 32'(v.data));
      if (v.hang) check({tag, " timeout latency"}, 32'(lat), 32'(TMO));
      @(negedge clk);
      check({tag, " done pulse"}, 32'(rsp_done), 32'd0);
      check({tag, " err pulse"}, 32'(rsp_err), 32'd0);
      check({tag, " idle en"}, 32'(mst_en), 32'd0);
      rdata_q.delete();
   endtask

   task automatic pair_round(input string tag);
      int   n;
      logic w;
      logic [6:0] a0, a1;
      m_rand = 1'b0;
      m_hang = 1'b0;
      m_busy = 4;
      @(negedge clk);
      a0 = 7'($urandom);
      a1 = 7'($urandom);
      set_req(1'b0, 1'b0, a0, 8'($urandom));
      set_req(1'b1, 1'b0, a1, 8'($urandom));
      req_valid = 2'b11;
      wait_ack(n);
      w = ~tb_last;
      check({tag, " first ack"}, 32'(req_ack), 32'(idx_onehot(w)));
      check({tag, " first addr"}, 32'(mst_addr), 32'(w ? a1 : a0));
      tb_last      = w;
      req_valid[w] = 1'b0;
      wait_done(n);
      check({tag, " first done"}, 32'(rsp_done), 32'(idx_onehot(w)));
      wait_ack(n);
      check({tag, " loser gap"}, 32'(n), 32'd2);
      check({tag, " second ack"}, 32'(req_ack), 32'(idx_onehot(~w)));
      check({tag, " second addr"}, 32'(mst_addr), 32'(w ? a0 : a1));
      tb_last       = ~w;
      req_valid[~w] = 1'b0;
      wait_done(n);
      check({tag, " second done"}, 32'(rsp_done), 32'(idx_onehot(~w)));
      @(negedge clk);
      rdata_q.delete();
   endtask

   task automatic reset_test();
      int n;
      int dones;
      m_rand  = 1'b0;
      m_hang  = 1'b0;
      m_busy  = 30;
      m_rdata = 8'h96;
      @(negedge clk);
      set_req(1'b0, 1'b1, 7'h55, 8'h6B);
      req_valid = 2'b01;
      wait_ack(n);
      check("rst pre ack", 32'(req_ack), 32'd1);
      tb_last   = 1'b0;
      req_valid = 2'b00;
      repeat (5) @(negedge clk);
      check("rst pre addr", 32'(mst_addr), 32'h55);
      #2 rst = 1'b0;
      #1;
      check("rst async en", 32'(mst_en), 32'd0);
      check("rst async ack", 32'(req_ack), 32'd0);
      check("rst async done", 32'(rsp_done), 32'd0);
      check("rst async err", 32'(rsp_err), 32'd0);
      check("rst async rdata", 32'(rsp_data), 32'd0);
      check("rst async addr", 32'(mst_addr), 32'd0);
      check("rst async wdata", 32'(mst_data), 32'd0);
      check("rst async rw", 32'(mst_rw), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst     = 1'b1;
      tb_last = 1'b1;
      dones   = 0;
      repeat (50) begin
         @(negedge clk);
         if (rsp_done != 2'b00) dones++;
      end
      check("rst no done", 32'(dones), 32'd0);
      rdata_q.delete();
      pair_round("post-rst");
   endtask

   task automatic random_test(input int cycles);
      int         n;
      bit         inflight;
      logic       exp_idx;
      logic       exp_rw;
      logic       r_rw[2];
      logic [6:0] r_addr[2];
      logic [7:0] r_data[2];
      n        = 0;
      inflight = 1'b0;
      exp_idx  = 1'b0;
      exp_rw   = 1'b0;
      m_rand   = 1'b1;
      m_hang   = 1'b0;
      rdata_q.delete();
      req_valid = 2'b00;
      while ((n < cycles || req_valid != 2'b00 || inflight) && n < cycles + 3000) begin
         @(negedge clk);
         n++;
         if (req_ack != 2'b00) begin
            logic w;
            w = (req_valid == 2'b11) ? ~tb_last : req_valid[1];
            check("rnd ack", 32'(req_ack), 32'(idx_onehot(w)));
            check("rnd ack while busy", 32'(inflight), 32'd0);
            check("rnd mst_addr", 32'(mst_addr), 32'(r_addr[w]));
            check("rnd mst_data", 32'(mst_data), 32'(r_data[w]));
            check("rnd mst_rw", 32'(mst_rw), 32'(r_rw[w]));
            inflight     = 1'b1;
            exp_idx      = w;
            exp_rw       = r_rw[w];
            tb_last      = w;
            req_valid[w] = 1'b0;
         end
         if (rsp_done != 2'b00) begin
            logic [7:0] q;
            check("rnd done expected", 32'(inflight), 32'd1);
            check("rnd read byte returned", 32'(rdata_q.size() > 0), 32'd1);
            q = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'h00;
            check("rnd done", 32'(rsp_done), 32'(idx_onehot(exp_idx)));
            check("rnd err", 32'(rsp_err), 32'd0);
            check("rnd data", 32'(rsp_data), 32'(exp_rw ? q : 8'h00));
            inflight = 1'b0;
         end
         if (n < cycles) begin
            for (int i = 0; i < 2; i++) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                  r_rw[i]   = 1'($urandom);
                  r_addr[i] = 7'($urandom);
                  r_data[i] = 8'($urandom);
                  set_req(1'(i), r_rw[i], r_addr[i], r_data[i]);
                  req_valid[i] = 1'b1;
               end
            end
         end
      end
      check("rnd drained", 32'({req_valid, inflight}), 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 2'b00;
      req_rw    = 2'b00;
      req_addr0 = '0;
      req_addr1 = '0;
      req_data0 = '0;
      req_data1 = '0;

      vecs[0] = '{1'b0, 1'b0, 7'h62, 8'hBA, 20, 8'hEE, 1'b0, 2'b01, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 7'h50, 8'h00, 12, 8'h3C, 1'b0, 2'b10, 1'b0, 8'h3C};
      vecs[2] = '{1'b0, 1'b1, 7'h11, 8'h5A,  3, 8'hA5, 1'b0, 2'b01, 1'b0, 8'hA5};
      vecs[3] = '{1'b1, 1'b0, 7'h7F, 8'h81,  1, 8'h99, 1'b0, 2'b10, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 1'b1, 7'h2A, 8'h44,  1, 8'h77, 1'b1, 2'b01, 1'b1, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 7'h33, 8'hC3,  5, 8'h77, 1'b0, 2'b10, 1'b0, 8'h00};

      #12;
      check("reset mst_en", 32'(mst_en), 32'd0);
      check("reset req_ack", 32'(req_ack), 32'd0);
      check("reset rsp_done", 32'(rsp_done), 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      check("reset rsp_data", 32'(rsp_data), 32'd0);
      check("reset mst_addr", 32'(mst_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      for (int r = 0; r < 3; r++) pair_round($sformatf("contend%0d", r));
      reset_test();
      random_test(1500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_arb_seq.md
I2C_ARB_SEQ -- requirements
Module: i2c_arb_seq

Interface
Parameters:
REQ-001 SHALL provide parameter TIMEOUT, default 16'd50000, meaning max cycles per transaction (ISSUE+BUSY) before abort.

Ports:
REQ-002 SHALL provide clk  in  1  system clock, rising edge.
REQ-003 SHALL provide rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide req_valid  in  2  per-requester transaction request, held until req_ack.
REQ-005 SHALL provide req_rw  in  2  per-requester direction, 1=read, 0=write.
REQ-006 SHALL provide req_addr0 / req_addr1  in  7 each  7-bit slave address.
REQ-007 SHALL provide req_data0 / req_data1  in  8 each  write byte.
REQ-008 SHALL provide req_ack  out  2  one-cycle pulse, request latched.
REQ-009 SHALL provide rsp_done  out  2  one-cycle pulse, transaction finished.
REQ-010 SHALL provide rsp_err  out  1  timeout indication, valid with rsp_done.
REQ-011 SHALL provide rsp_data  out  8  read byte, valid with rsp_done.
REQ-012 SHALL provide mst_en, mst_rw  out  1 each  i2c_master enable/direction.
REQ-013 SHALL provide mst_addr  out  7  and mst_data  out  8  i2c_master address/write byte.
REQ-014 SHALL provide mst_ready  in  1  (master idle) and mst_data_out  in  8  (master read byte).

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, BUSY, DONE.
REQ-016 IDLE: grant only when mst_ready=1 and any req_valid=1; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin:
- single valid wins;
- both valid: grant the index not granted last;
- after reset, index 0 has priority.
REQ-018 On grant (IDLE, cycle t), SHALL:
- latch rw/addr/data of the winner;
- enter ISSUE at t+1;
- pulse req_ack[winner] during cycle t+1.
REQ-019 mst_addr/mst_data/mst_rw SHALL be driven from the latched registers only, stable from ISSUE through DONE.
REQ-020 mst_en SHALL be 1 only in ISSUE; ISSUE -> BUSY on the first cycle mst_ready=0 (accepted).
REQ-021 BUSY -> DONE on the first cycle mst_ready=1.
REQ-022 On BUSY -> DONE, SHALL capture rsp_data = mst_data_out if rw=1, else 8'h00.
REQ-023 DONE SHALL last exactly one cycle, then return to IDLE:
- pulse rsp_done[granted] in DONE;
- assert rsp_err for that cycle if DONE was entered by timeout.
REQ-024 Timeout counter (16-bit):
- cleared on ISSUE entry; increments each cycle in ISSUE/BUSY;
- at TIMEOUT-1, SHALL enter DONE with rsp_err=1 and rsp_data=8'h00.
REQ-025 Losing requester's req_valid stays pending and SHALL be granted in the next eligible IDLE cycle; minimum one IDLE cycle between transactions.
REQ-026 req_valid changes outside IDLE SHALL have no effect on the in-flight transaction.
REQ-027 At most one bit of req_ack and one bit of rsp_done SHALL be high in any cycle.

Reset
REQ-028 rst=0 SHALL, asynchronously:
- force IDLE;
- clear mst_en, req_ack, rsp_done, rsp_err, rsp_data, mst_addr, mst_data, mst_rw, timeout counter;
- set round-robin pointer to favour index 0.
REQ-029 Reset mid-transaction SHALL drop mst_en immediately and emit no rsp_done for the aborted transaction.

Structure
REQ-030 Package i2c_pkg SHALL hold the FSM state enum, ADDR_W=7, DATA_W=8 and the default TIMEOUT constant.
REQ-031 The 2-way round-robin grant logic SHALL be a sub-module i2c_rr_arbiter; i2c_arb_seq connects to i2c_master in the top level.

Verification
REQ-032 Single write: req_valid=2'b01, addr0=7'h62, data0=8'hBA, rw=0; master model drops ready for 20 cycles. Required:
- req_ack=2'b01 at t+1;
- mst_addr=7'h62, mst_data=8'hBA;
- rsp_done=2'b01, rsp_err=0, rsp_data=8'h00.
REQ-033 Read: requester 1, addr1=7'h50, rw=1; model returns 8'h3C. Required: rsp_done=2'b10, rsp_data=8'h3C.
REQ-034 Contention: both valid at the same cycle, repeated three times. Required: grant order 0,1,0; each loser is served directly after the winner's DONE.
REQ-035 Timeout: TIMEOUT=16'd100, model never drops mst_ready. Required: rsp_done plus rsp_err=1 exactly 100 cycles after ISSUE entry, then IDLE.
REQ-036 Reset mid-BUSY: rst low for 2 cycles. Required:
- mst_en=0 and outputs cleared without a clock edge;
- no rsp_done;
- next request with both valid grants index 0.
